// File: rtl/led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_ctrl
// Description : Command-driven LED pattern generator. A rising edge on
//               inValid samples an LED index (dataIn) and a mode. The block
//               then drives a registered one-hot or blank pattern on ledOut:
//               steady, blink, chase (rotating) or off. An internal prescaler
//               of TICK_DIV clocks paces the blink and chase steps.
// Ports       : clk     - system clock
//               rst     - synchronous reset, active-high
//               dataIn  - LED index carried by the command
//               mode    - 00 steady, 01 blink, 10 chase, 11 off
//               inValid - command strobe, rising edge only
//               ledOut  - registered LED drive, at most one bit set
//               cmdAck  - one-cycle pulse, command accepted
//               cmdErr  - one-cycle pulse, command rejected (index too big)
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_ctrl #(
  parameter int NUM_LEDS = 4,
  parameter int SEL_W    = 2,
  parameter int TICK_DIV = 5_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SEL_W-1:0]    dataIn,
  input  logic [1:0]          mode,
  input  logic                inValid,
  output logic [NUM_LEDS-1:0] ledOut,
  output logic                cmdAck,
  output logic                cmdErr
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  // One extra bit so the range check also works when NUM_LEDS == 2**SEL_W.
  localparam logic [SEL_W:0]   LED_LIMIT = (SEL_W + 1)'(NUM_LEDS);
  localparam logic [SEL_W-1:0] POS_LAST  = SEL_W'(NUM_LEDS - 1);

  // Encoding matches the mode field so an accepted command loads it directly.
  typedef enum logic [1:0] {
    STEADY = 2'b00,
    BLINK  = 2'b01,
    CHASE  = 2'b10,
    OFF    = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    pos_q, pos_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic                valid_prev;
  logic [NUM_LEDS-1:0] led_d;
  logic                ack_d, err_d;
  logic                evt, in_range, tick;
  logic [NUM_LEDS-1:0] onehot;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= OFF;
      pos_q      <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      // Treat inValid as already high so a strobe held across reset is ignored.
      valid_prev <= 1'b1;
      ledOut     <= '0;
      cmdAck     <= 1'b0;
      cmdErr     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      valid_prev <= inValid;
      ledOut     <= led_d;
      cmdAck     <= ack_d;
      cmdErr     <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    led_d    = '0;

    evt      = inValid & ~valid_prev;
    in_range = ({1'b0, dataIn} < LED_LIMIT);
    tick     = ((state_q == BLINK) || (state_q == CHASE)) && (cnt_q == TICK_LAST);

    if (evt && in_range) begin
      // A command overrides any running pattern; a coincident tick is dropped.
      state_d = state_t'(mode);
      pos_d   = dataIn;
      cnt_d   = '0;
      phase_d = 1'b1;
      ack_d   = 1'b1;
    end else if (evt) begin
      // Rejected command freezes everything for this cycle.
      err_d = 1'b1;
    end else begin
      case (state_q)
        BLINK: begin
          cnt_d = tick ? '0 : cnt_q + 1'b1;
          if (tick) phase_d = ~phase_q;
        end
        CHASE: begin
          cnt_d = tick ? '0 : cnt_q + 1'b1;
          if (tick) pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
        end
        default: cnt_d = '0;
      endcase
    end

    // The output register is loaded from next-state so a new pattern appears
    // on the same edge that accepts the command.
    onehot = NUM_LEDS'(1) << pos_d;
    case (state_d)
      STEADY:  led_d = onehot;
      BLINK:   led_d = phase_d ? onehot : '0;
      CHASE:   led_d = onehot;
      default: led_d = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pattern_ctrl
// Description : Directed self-checking bench for led_pattern_ctrl. One
//               4-LED instance covers reset, steady, blink, chase and the
//               collision cases; a 3-LED instance covers reject and the
//               rising-edge filter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dataIn, mode;
  logic       inValid;
  logic [3:0] ledOut;
  logic       cmdAck, cmdErr;

  logic [1:0] dataIn3, mode3;
  logic       inValid3;
  logic [2:0] ledOut3;
  logic       cmdAck3, cmdErr3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  led_pattern_ctrl #(.NUM_LEDS(4), .SEL_W(2), .TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .dataIn(dataIn), .mode(mode), .inValid(inValid),
    .ledOut(ledOut), .cmdAck(cmdAck), .cmdErr(cmdErr)
  );

  led_pattern_ctrl #(.NUM_LEDS(3), .SEL_W(2), .TICK_DIV(4)) dut3 (
    .clk(clk), .rst(rst), .dataIn(dataIn3), .mode(mode3), .inValid(inValid3),
    .ledOut(ledOut3), .cmdAck(cmdAck3), .cmdErr(cmdErr3)
  );

  // Advance one clock and settle just after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drop inValid for one cycle then raise it with the given command;
  // returns just after the accepting edge (cycle 0 of the new pattern).
  task automatic cmd(input logic [1:0] d, input logic [1:0] m);
    inValid = 1'b0;
    cycle();
    dataIn  = d;
    mode    = m;
    inValid = 1'b1;
    cycle();
  endtask

  initial begin
    logic [3:0] exp4;
    rst = 1'b1; inValid = 1'b1; dataIn = 2'd0; mode = 2'b00;
    inValid3 = 1'b0; dataIn3 = 2'd0; mode3 = 2'b00;

    // 1. Reset with inValid held high, then held high after release.
    cycle(); cycle();
    chk("reset_led", 8'(ledOut), 8'h0);
    chk("reset_ack", 8'(cmdAck), 8'h0);
    chk("reset_err", 8'(cmdErr), 8'h0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("hold_led", 8'(ledOut), 8'h0);
      chk("hold_ack", 8'(cmdAck), 8'h0);
    end

    // 2. Steady one-hot decode.
    cmd(2'd2, 2'b00);
    chk("steady2_ack", 8'(cmdAck), 8'h1);
    chk("steady2_led", 8'(ledOut), 8'h4);
    inValid = 1'b0;
    cycle();
    chk("steady2_ack_pulse", 8'(cmdAck), 8'h0);
    chk("steady2_led_hold", 8'(ledOut), 8'h4);
    cycle(); cycle(); cycle(); cycle();
    chk("steady2_led_late", 8'(ledOut), 8'h4);
    cmd(2'd0, 2'b00);
    chk("steady0_led", 8'(ledOut), 8'h1);
    cmd(2'd1, 2'b00);
    chk("steady1_led", 8'(ledOut), 8'h2);
    cmd(2'd3, 2'b00);
    chk("steady3_led", 8'(ledOut), 8'h8);
    chk("steady3_ack", 8'(cmdAck), 8'h1);

    // 3. Blink on LED 1: on 0-3, off 4-7, on 8-11.
    cmd(2'd1, 2'b01);
    inValid = 1'b0;
    chk("blink_c0", 8'(ledOut), 8'h2);
    for (int i = 1; i < 12; i++) begin
      cycle();
      exp4 = (i < 4 || i >= 8) ? 4'b0010 : 4'b0000;
      chk($sformatf("blink_c%0d", i), 8'(ledOut), 8'(exp4));
    end
    cmd(2'd0, 2'b11);
    chk("off_led", 8'(ledOut), 8'h0);
    chk("off_ack", 8'(cmdAck), 8'h1);

    // 4. Chase from LED 3 with wrap to LED 0.
    cmd(2'd3, 2'b10);
    inValid = 1'b0;
    chk("chase_c0", 8'(ledOut), 8'h8);
    for (int i = 1; i <= 16; i++) begin
      cycle();
      case ((3 + i / 4) % 4)
        0:       exp4 = 4'b0001;
        1:       exp4 = 4'b0010;
        2:       exp4 = 4'b0100;
        default: exp4 = 4'b1000;
      endcase
      chk($sformatf("chase_c%0d", i), 8'(ledOut), 8'(exp4));
    end

    // 6a. Command landing on the chase tick edge (cycle 20): the tick is
    //     dropped, the new pattern starts and the prescaler restarts.
    cycle(); cycle(); cycle();
    dataIn = 2'd1; mode = 2'b10; inValid = 1'b1;
    cycle();
    chk("collide_ack", 8'(cmdAck), 8'h1);
    chk("collide_led", 8'(ledOut), 8'h2);
    inValid = 1'b0;
    cycle(); cycle(); cycle();
    chk("collide_c3", 8'(ledOut), 8'h2);
    cycle();
    chk("collide_c4", 8'(ledOut), 8'h4);

    // 6b. Reset in the middle of a blink.
    cmd(2'd0, 2'b01);
    inValid = 1'b0;
    cycle(); cycle();
    chk("midblink_led", 8'(ledOut), 8'h1);
    rst = 1'b1;
    cycle();
    chk("midblink_rst_led", 8'(ledOut), 8'h0);
    rst = 1'b0;
    cycle();
    chk("midblink_after_led", 8'(ledOut), 8'h0);

    // Reset coinciding with a rising inValid: no ack, and the held strobe
    // must not be seen as a command afterwards.
    rst = 1'b1; dataIn = 2'd2; mode = 2'b00; inValid = 1'b1;
    cycle();
    chk("rst_evt_ack", 8'(cmdAck), 8'h0);
    chk("rst_evt_led", 8'(ledOut), 8'h0);
    rst = 1'b0;
    cycle();
    chk("rst_evt_hold_ack", 8'(cmdAck), 8'h0);
    chk("rst_evt_hold_led", 8'(ledOut), 8'h0);
    inValid = 1'b0;

    // 5. Three-LED instance: reject of index 3 and rising-edge filter.
    dataIn3 = 2'd1; mode3 = 2'b00; inValid3 = 1'b1;
    cycle();
    chk("n3_accept_ack", 8'(cmdAck3), 8'h1);
    chk("n3_accept_led", 8'(ledOut3), 8'h2);
    inValid3 = 1'b0;
    cycle();
    dataIn3 = 2'd3; inValid3 = 1'b1;
    cycle();
    chk("n3_reject_err", 8'(cmdErr3), 8'h1);
    chk("n3_reject_ack", 8'(cmdAck3), 8'h0);
    chk("n3_reject_led", 8'(ledOut3), 8'h2);
    cycle();
    chk("n3_err_pulse", 8'(cmdErr3), 8'h0);
    dataIn3 = 2'd2;
    cycle();
    chk("n3_noedge_ack", 8'(cmdAck3), 8'h0);
    chk("n3_noedge_err", 8'(cmdErr3), 8'h0);
    chk("n3_noedge_led", 8'(ledOut3), 8'h2);
    inValid3 = 1'b0;
    cycle();
    inValid3 = 1'b1;
    cycle();
    chk("n3_fresh_led", 8'(ledOut3), 8'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
